// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS program-memory read channels among
// NUM_CONSUMERS instruction fetchers using 4-phase valid/ready handshakes.
module fetch_arbiter #(
   parameter int ADDRESS_BITS  = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDRESS_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0]    consumer_read_data,
   output logic [NUM_CHANNELS-1:0]               mem_read_valid,
   output logic [NUM_CHANNELS*ADDRESS_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]               mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]     mem_read_data
);

   localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {IDLE, WAITING, RELAYING} chan_state_t;

   chan_state_t                         state_q   [NUM_CHANNELS];
   chan_state_t                         state_nxt [NUM_CHANNELS];
   logic [IDX_W-1:0]                    owner_q   [NUM_CHANNELS];
   logic [IDX_W-1:0]                    owner_nxt [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]             mem_valid_q, mem_valid_nxt;
   logic [NUM_CHANNELS*ADDRESS_BITS-1:0] mem_addr_q, mem_addr_nxt;
   logic [NUM_CONSUMERS-1:0]            cons_ready_q, cons_ready_nxt;
   logic [NUM_CONSUMERS*DATA_BITS-1:0]  cons_data_q, cons_data_nxt;
   logic [NUM_CONSUMERS-1:0]            claimed_q, claimed_nxt;
   logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_nxt;

   logic [NUM_CONSUMERS-1:0]            pending;
   logic [NUM_CONSUMERS-1:0]            taken;
   logic                                found;
   logic [IDX_W-1:0]                    idx_v;

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         state_nxt[c] = state_q[c];
         owner_nxt[c] = owner_q[c];
      end
      mem_valid_nxt  = mem_valid_q;
      mem_addr_nxt   = mem_addr_q;
      cons_ready_nxt = cons_ready_q;
      cons_data_nxt  = cons_data_q;
      claimed_nxt    = claimed_q;
      rr_ptr_nxt     = rr_ptr_q;
      pending        = consumer_read_valid & ~claimed_q;
      taken          = '0;
      found          = 1'b0;
      idx_v          = '0;

      // Channels are visited in ascending order so the last grant sets rr_ptr.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         case (state_q[c])
            IDLE: begin
               found = 1'b0;
               for (int j = 0; j < NUM_CONSUMERS; j++) begin
                  idx_v = IDX_W'((int'(rr_ptr_q) + j) % NUM_CONSUMERS);
                  if (!found && pending[idx_v] && !taken[idx_v]) begin
                     found            = 1'b1;
                     taken[idx_v]     = 1'b1;
                     claimed_nxt[idx_v] = 1'b1;
                     owner_nxt[c]     = idx_v;
                     state_nxt[c]     = WAITING;
                     mem_valid_nxt[c] = 1'b1;
                     mem_addr_nxt[c*ADDRESS_BITS +: ADDRESS_BITS] =
                        consumer_read_address[int'(idx_v)*ADDRESS_BITS +: ADDRESS_BITS];
                     rr_ptr_nxt = IDX_W'((int'(idx_v) + 1) % NUM_CONSUMERS);
                  end
               end
            end
            WAITING: begin
               if (mem_read_ready[c]) begin
                  mem_valid_nxt[c]              = 1'b0;
                  cons_ready_nxt[owner_q[c]]    = 1'b1;
                  cons_data_nxt[int'(owner_q[c])*DATA_BITS +: DATA_BITS] =
                     mem_read_data[c*DATA_BITS +: DATA_BITS];
                  state_nxt[c]                  = RELAYING;
               end
            end
            RELAYING: begin
               // Only a dropped valid ends the transfer; a held valid is not a new request.
               if (!consumer_read_valid[owner_q[c]]) begin
                  cons_ready_nxt[owner_q[c]] = 1'b0;
                  claimed_nxt[owner_q[c]]    = 1'b0;
                  state_nxt[c]               = IDLE;
               end
            end
            default: state_nxt[c] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= IDLE;
            owner_q[c] <= '0;
         end
         mem_valid_q  <= '0;
         mem_addr_q   <= '0;
         cons_ready_q <= '0;
         cons_data_q  <= '0;
         claimed_q    <= '0;
         rr_ptr_q     <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= state_nxt[c];
            owner_q[c] <= owner_nxt[c];
         end
         mem_valid_q  <= mem_valid_nxt;
         mem_addr_q   <= mem_addr_nxt;
         cons_ready_q <= cons_ready_nxt;
         cons_data_q  <= cons_data_nxt;
         claimed_q    <= claimed_nxt;
         rr_ptr_q     <= rr_ptr_nxt;
      end
   end

   assign consumer_read_ready = cons_ready_q;
   assign consumer_read_data  = cons_data_q;
   assign mem_read_valid      = mem_valid_q;
   assign mem_read_address    = mem_addr_q;

endmodule

// File: doc/fetch_arbiter.md
Name: fetch_arbiter

Overview:
- Shares one multi-channel program-memory read port among NUM_CONSUMERS per-core instruction fetchers.
- Each fetcher uses a 4-phase valid/ready read handshake. The arbiter grants fetchers to free memory channels in round-robin order, forwards the address, returns the instruction word, and holds it until the fetcher releases.
- Sits between the cores' fetchers and the external program-memory interface.

Parameters:
- ADDRESS_BITS, 8, program-memory address width
- DATA_BITS, 16, instruction word width
- NUM_CONSUMERS, 4, number of fetchers (>=1)
- NUM_CHANNELS, 1, concurrent memory read channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request
- consumer_read_address  in  NUM_CONSUMERS*ADDRESS_BITS  packed; consumer i at [i*ADDRESS_BITS +: ADDRESS_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  data valid for consumer i
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed per consumer
- mem_read_valid  out  NUM_CHANNELS  channel request to memory
- mem_read_address  out  NUM_CHANNELS*ADDRESS_BITS  packed per channel
- mem_read_ready  in  NUM_CHANNELS  memory data valid for channel
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed per channel

Behaviour:
- All outputs are registered.
- Reset (applies any cycle, including mid-transaction):
  - all outputs go to 0;
  - every channel goes to IDLE;
  - all claimed flags are cleared;
  - rr_ptr goes to 0.
  - An in-flight memory response is dropped.
- Per-channel FSM:
  - IDLE: the channel may accept a grant. On grant, next edge: record consumer index k, mem_read_valid[c]=1, mem_read_address[c]=consumer_read_address[k], claimed[k]=1, state WAITING.
  - WAITING: hold valid and address. When mem_read_ready[c]=1, next edge: mem_read_valid[c]=0, consumer_read_data[k]=mem_read_data[c], consumer_read_ready[k]=1, state RELAYING.
  - RELAYING: hold ready and data. When consumer_read_valid[k]=0, next edge: consumer_read_ready[k]=0, claimed[k]=0, state IDLE.
- A consumer is pending iff consumer_read_valid[k]=1 and claimed[k]=0.
- Grant, each cycle:
  - Idle channels are taken in ascending channel index.
  - Each takes the next pending consumer, searching circularly from rr_ptr and skipping consumers already granted this cycle.
  - No consumer is granted to two channels.
  - If any grant occurs, rr_ptr = (last granted index + 1) mod NUM_CONSUMERS. Otherwise rr_ptr holds.
- Latency, uncontended:
  - request sampled at edge N -> mem_read_valid high after N;
  - mem_read_ready sampled at edge M -> consumer_read_ready high after M;
  - memory ready in the first WAITING cycle gives 2 cycles from request to data.
- Release to re-grant: a consumer dropping valid at edge R is IDLE after R. If it reasserts, it can be granted at edge R+1 at the earliest. A re-request while still RELAYING is never seen as a new request.
- Address changes from a consumer after grant are ignored; the latched address is used.
- mem_read_ready on an IDLE or RELAYING channel is ignored.
- consumer_read_data[k] holds its last value after ready drops; only ready qualifies it.
- No starvation: with all consumers requesting and NUM_CHANNELS=1, grant order is 0,1,2,3,0,...

Test Plan:
- Reset, single request: NUM_CHANNELS=1, consumer 2 requests addr 0x1A, memory ready 3 cycles after valid with data 0xBEEF -> mem_read_address=0x1A; consumer_read_ready[2]=1 with data 0xBEEF one cycle after mem ready; ready drops one cycle after valid[2] drops.
- All 4 consumers request with addrs 0x10,0x20,0x30,0x40, single channel, memory ready 1 cycle -> memory sees 0x10,0x20,0x30,0x40 in order. After consumer 0 re-requests, it is served after consumer 3.
- NUM_CHANNELS=2, consumers 1 and 3 request in the same cycle -> channel 0 gets consumer 1, channel 1 gets consumer 3 in the same cycle; rr_ptr=0. Independent completion with data 0x1111/0x3333 goes to the correct consumers.
- Consumer holds valid high for 5 cycles after ready -> no second memory request is issued; ready stays high until valid drops.
- Reset asserted while a channel is WAITING, then mem_read_ready pulses -> all outputs 0, no consumer ready. A fresh request afterwards completes normally.
- Consumer changes its address after grant -> memory keeps the original address until data returns.
